// File: rtl/zports.sv
// Port register file behind the ZX-bus interface: synchronised write capture,
// ROM-map / W5300 mode config, chip reset pulse generators and interrupt request.
module zports #(
  parameter int unsigned RST_LEN = 64,
  parameter logic [3:0]  VERSION = 4'h1
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       ports_wrena,
  input  logic       ports_wrstb_n,
  input  logic [1:0] ports_addr,
  input  logic [7:0] ports_wrdata,
  output logic [7:0] ports_rddata,
  output logic [1:0] rommap_win,
  output logic       rommap_ena,
  output logic       w5300_ports,
  output logic       sl811_rst_n,
  output logic       w5300_rst_n,
  input  logic       sl811_intr,
  input  logic       w5300_int_n,
  output logic       int_req
);

  localparam logic [15:0] RST_LOAD = 16'(RST_LEN);

  // stb_sync[1:0] is the 2-flop synchroniser, stb_sync[2] the history flop.
  logic [2:0]  stb_sync;
  logic        wr_evt;
  logic [1:0]  inten;
  logic [1:0]  sl_sync;
  logic [1:0]  w_sync;
  logic [1:0]  trig;
  logic [15:0] cnt_sl, cnt_w;
  logic [15:0] nxt_sl, nxt_w;

  assign wr_evt = stb_sync[2] & ~stb_sync[1] & ports_wrena;
  assign trig   = (wr_evt && ports_addr == 2'b01) ? ports_wrdata[5:4] : 2'b00;

  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      stb_sync    <= 3'b111;
      rommap_ena  <= 1'b0;
      rommap_win  <= 2'b00;
      w5300_ports <= 1'b0;
      inten       <= 2'b00;
    end else begin
      stb_sync <= {stb_sync[1:0], ports_wrstb_n};
      if (wr_evt && ports_addr == 2'b01) begin
        rommap_ena  <= ports_wrdata[0];
        rommap_win  <= ports_wrdata[2:1];
        w5300_ports <= ports_wrdata[3];
      end
      if (wr_evt && ports_addr == 2'b10)
        inten <= ports_wrdata[1:0];
    end
  end

  // A trigger always reloads, so a retrigger while busy stretches the pulse.
  always_comb begin
    nxt_sl = 16'd0;
    nxt_w  = 16'd0;
    if (trig[0])           nxt_sl = RST_LOAD;
    else if (cnt_sl != 0)  nxt_sl = cnt_sl - 16'd1;
    if (trig[1])           nxt_w  = RST_LOAD;
    else if (cnt_w != 0)   nxt_w  = cnt_w - 16'd1;
  end

  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      cnt_sl      <= RST_LOAD;
      cnt_w       <= RST_LOAD;
      sl811_rst_n <= 1'b0;
      w5300_rst_n <= 1'b0;
    end else begin
      cnt_sl      <= nxt_sl;
      cnt_w       <= nxt_w;
      sl811_rst_n <= (nxt_sl == 16'd0);
      w5300_rst_n <= (nxt_w == 16'd0);
    end
  end

  // W5300 interrupt is stored active-high after synchronisation.
  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      sl_sync <= 2'b00;
      w_sync  <= 2'b00;
      int_req <= 1'b0;
    end else begin
      sl_sync <= {sl_sync[0], sl811_intr};
      w_sync  <= {w_sync[0], ~w5300_int_n};
      int_req <= (sl_sync[1] & inten[0]) | (w_sync[1] & inten[1]);
    end
  end

  always_comb begin
    ports_rddata = 8'hFF;
    case (ports_addr)
      2'b00: ports_rddata = 8'hFF;
      2'b01: ports_rddata = {4'b0000, w5300_ports, rommap_win, rommap_ena};
      2'b10: ports_rddata = {6'b000000, inten};
      2'b11: ports_rddata = {VERSION, ~w5300_rst_n, ~sl811_rst_n, w_sync[1], sl_sync[1]};
      default: ports_rddata = 8'hFF;
    endcase
  end

endmodule
